// File: rtl/freq_meter_pkg.sv
// Shared types and sizing helpers for the kernel-clock frequency meter.
package freq_meter_pkg;

    // Measurement FSM: idle (gate held at 0) or counting inside a gate window.
    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } meter_state_e;

    // Production defaults: 1 s window at 50 MHz, kernel clock divided by 16.
    localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
    localparam int unsigned DEF_DIV_LOG2    = 4;
    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Edge counter width: the low DIV_LOG2 result bits are always zero.
    function automatic int unsigned edge_width(input int unsigned cnt_w,
                                               input int unsigned div_log2);
        return cnt_w - div_log2;
    endfunction

    // Gate counter width: must hold GATE_CYCLES-1.
    function automatic int unsigned gate_cnt_width(input int unsigned gate_cycles);
        return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/bit_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bit plus a rising-edge pulse.
module bit_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // Shift the async bit through the chain; history flop remembers the last synced level.
    always_comb begin
        sync_d[0] = d_async;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/kernel_clk_freq_meter.sv
// Counts rising edges of a divided kernel clock over a fixed gate window and
// reports kernel cycles per window through a valid/ready result register.
module kernel_clk_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned DIV_LOG2    = DEF_DIV_LOG2,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             fpga_clk_50,
    input  logic             fpga_reset_n,
    input  logic             enable,
    input  logic             div_clk_async,
    output logic [CNT_W-1:0] result_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_overrun,
    output logic             clk_stopped,
    output logic             count_saturated
);

    localparam int unsigned EDGE_W = edge_width(CNT_W, DIV_LOG2);
    localparam int unsigned GATE_W = gate_cnt_width(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              edge_pulse;
    meter_state_e      state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [EDGE_W-1:0] edge_final;
    logic [CNT_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              stopped_q, stopped_d;
    logic              sat_q, sat_d;
    logic              accept;

    bit_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (fpga_clk_50),
        .rst_n      (fpga_reset_n),
        .d_async    (div_clk_async),
        .edge_pulse (edge_pulse)
    );

    // Edge count including this cycle's pulse; sticks at all-ones instead of wrapping.
    always_comb begin
        edge_final = edge_cnt_q;
        if (edge_pulse && !(&edge_cnt_q)) begin
            edge_final = edge_cnt_q + EDGE_W'(1);
        end
    end

    // FSM next state, gate/edge counters, and result handshake.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        stopped_d  = stopped_q;
        sat_d      = sat_q;
        accept     = valid_q & result_ready;

        if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                if (enable) begin
                    state_d = GATE;
                end
            end
            GATE: begin
                if (!enable) begin
                    // Abort: partial window is thrown away, result regs untouched.
                    state_d    = IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    // Window end: publish and restart immediately so no cycle goes uncounted.
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    data_d     = CNT_W'(edge_final) << DIV_LOG2;
                    stopped_d  = (edge_final == '0);
                    sat_d      = &edge_final;
                    valid_d    = 1'b1;
                    overrun_d  = valid_q & ~result_ready;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = edge_final;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            stopped_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            stopped_q  <= stopped_d;
            sat_q      <= sat_d;
        end
    end

    assign result_data     = data_q;
    assign result_valid    = valid_q;
    assign result_overrun  = overrun_q;
    assign clk_stopped     = stopped_q;
    assign count_saturated = sat_q;

endmodule

// File: tb/tb_kernel_clk_freq_meter.sv
// Directed bench for kernel_clk_freq_meter with a result scoreboard.
module tb_kernel_clk_freq_meter;

    localparam int unsigned GATE_CYCLES = 100;
    localparam int unsigned DIV_LOG2    = 2;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned SYNC_STAGES = 2;

    logic             fpga_clk_50;
    logic             fpga_reset_n;
    logic             enable;
    logic             div_clk_async;
    logic [CNT_W-1:0] result_data;
    logic             result_valid;
    logic             result_ready;
    logic             result_overrun;
    logic             clk_stopped;
    logic             count_saturated;

    typedef struct {
        logic [CNT_W-1:0] data;
        logic             stopped;
        logic             sat;
        bit               chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   tog_run = 1'b0;
    int   tog_cnt = 0;

    kernel_clk_freq_meter #(
        .GATE_CYCLES (GATE_CYCLES),
        .DIV_LOG2    (DIV_LOG2),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .fpga_clk_50     (fpga_clk_50),
        .fpga_reset_n    (fpga_reset_n),
        .enable          (enable),
        .div_clk_async   (div_clk_async),
        .result_data     (result_data),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_overrun  (result_overrun),
        .clk_stopped     (clk_stopped),
        .count_saturated (count_saturated)
    );

    initial begin
        fpga_clk_50 = 1'b0;
        forever #5 fpga_clk_50 = ~fpga_clk_50;
    end

    // Divided-clock source: period 10 fpga clocks while running, held low otherwise.
    initial begin
        div_clk_async = 1'b0;
        forever begin
            @(posedge fpga_clk_50);
            #2;
            if (tog_run) begin
                tog_cnt++;
                if (tog_cnt == 5) begin
                    div_clk_async = ~div_clk_async;
                    tog_cnt = 0;
                end
            end else begin
                div_clk_async = 1'b0;
                tog_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fpga_clk_50);
        #1;
    endtask

    task automatic push_exp(input logic [CNT_W-1:0] d, input logic s, input bit chk);
        exp_t e;
        e.data    = d;
        e.stopped = s;
        e.sat     = 1'b0;
        e.chk     = chk;
        sb_q.push_back(e);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 400) begin
            step();
            cyc++;
        end
        check("valid_timeout", 32'(result_valid), 32'd1);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    // Scoreboard: every accepted result is matched against the oldest expectation.
    always @(negedge fpga_clk_50) begin : monitor
        exp_t e;
        if (fpga_reset_n && result_valid && result_ready) begin
            $display("txn t=%0t data=%0d stopped=%0b sat=%0b overrun=%0b",
                     $time, result_data, clk_stopped, count_saturated, result_overrun);
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    check("rd_data", 32'(result_data), 32'(e.data));
                    check("rd_stopped", 32'(clk_stopped), 32'(e.stopped));
                    check("rd_sat", 32'(count_saturated), 32'(e.sat));
                end
            end
        end
    end

    initial begin
        int cyc;
        fpga_reset_n = 1'b0;
        enable       = 1'b0;
        result_ready = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_data", 32'(result_data), 32'd0);
        check("rst_overrun", 32'(result_overrun), 32'd0);
        check("rst_stopped", 32'(clk_stopped), 32'd0);
        check("rst_sat", 32'(count_saturated), 32'd0);
        fpga_reset_n = 1'b1;

        // Basic window: 10 edges per 100 cycles -> 40.
        tog_run = 1'b1;
        repeat (20) step();
        enable = 1'b1;
        push_exp(16'd40, 1'b0, 1'b1);
        wait_valid(cyc);
        check("lat_first", 32'(cyc), 32'd101);
        check("ovr_first", 32'(result_overrun), 32'd0);
        consume();
        check("acc_valid", 32'(result_valid), 32'd0);

        // Stopped clock, then recovery.
        enable = 1'b0;
        step();
        tog_run = 1'b0;
        repeat (20) step();
        enable = 1'b1;
        push_exp(16'd0, 1'b1, 1'b1);
        wait_valid(cyc);
        check("lat_stop", 32'(cyc), 32'd101);
        consume();
        enable = 1'b0;
        tog_run = 1'b1;
        repeat (20) step();
        enable = 1'b1;
        push_exp(16'd40, 1'b0, 1'b1);
        wait_valid(cyc);
        consume();

        // Three unaccepted windows; the third sees a stopped clock.
        enable = 1'b0;
        repeat (20) step();
        enable = 1'b1;
        push_exp(16'd0, 1'b1, 1'b1);
        repeat (150) step();
        tog_run = 1'b0;
        repeat (160) step();
        check("ovr_valid", 32'(result_valid), 32'd1);
        check("ovr_set", 32'(result_overrun), 32'd1);
        consume();
        check("ovr_acc_valid", 32'(result_valid), 32'd0);
        check("ovr_acc_clear", 32'(result_overrun), 32'd0);

        // Accept coinciding with a new latch.
        enable = 1'b0;
        tog_run = 1'b1;
        repeat (20) step();
        enable = 1'b1;
        push_exp(16'd0, 1'b0, 1'b0);
        push_exp(16'd0, 1'b1, 1'b1);
        repeat (150) step();
        tog_run = 1'b0;
        repeat (150) step();
        check("co_pre_ovr", 32'(result_overrun), 32'd1);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("co_valid", 32'(result_valid), 32'd1);
        check("co_ovr", 32'(result_overrun), 32'd0);
        consume();
        check("co_acc_valid", 32'(result_valid), 32'd0);

        // Abort at gate_cnt=50, then a full window after re-enable.
        enable = 1'b0;
        tog_run = 1'b1;
        repeat (20) step();
        enable = 1'b1;
        push_exp(16'd40, 1'b0, 1'b1);
        wait_valid(cyc);
        check("lat_ab0", 32'(cyc), 32'd101);
        consume();
        repeat (49) step();
        enable = 1'b0;
        repeat (150) step();
        check("ab_valid", 32'(result_valid), 32'd0);
        check("ab_data", 32'(result_data), 32'd40);
        check("ab_stopped", 32'(clk_stopped), 32'd0);
        enable = 1'b1;
        push_exp(16'd40, 1'b0, 1'b1);
        wait_valid(cyc);
        check("lat_ab1", 32'(cyc), 32'd101);
        consume();

        // Asynchronous reset mid-window with a pending result.
        wait_valid(cyc);
        repeat (50) step();
        #2;
        fpga_reset_n = 1'b0;
        #1;
        check("ar_valid", 32'(result_valid), 32'd0);
        check("ar_data", 32'(result_data), 32'd0);
        check("ar_overrun", 32'(result_overrun), 32'd0);
        check("ar_stopped", 32'(clk_stopped), 32'd0);
        check("ar_sat", 32'(count_saturated), 32'd0);
        tog_run = 1'b0;
        enable = 1'b0;
        repeat (5) step();
        fpga_reset_n = 1'b1;
        step();
        tog_run = 1'b1;
        repeat (20) step();
        enable = 1'b1;
        push_exp(16'd40, 1'b0, 1'b1);
        wait_valid(cyc);
        check("lat_ar", 32'(cyc), 32'd101);
        consume();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
